// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the GPIO bus arbiter: FSM encoding, op encoding,
// error read-data pattern and the latched request payload.
package gpio_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam logic [DATA_W-1:0] GPIO_ARB_ERR_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } gpio_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant+1 (mod N)
// and returns the first requester as one-hot and as an index.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [N-1:0]         grant_c,
    output logic [$clog2(N)-1:0] grant_idx_c,
    output logic                 any_req_c
);

    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        any_req_c   = 1'b0;
        cand        = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IDX_W'((32'(last_grant) + i) % N);
            if (!any_req_c && req[cand]) begin
                any_req_c   = 1'b1;
                grant_idx_c = cand;
                grant_c     = N'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Round-robin sharing of the single GPIO peripheral port between NUM_MASTERS requesters.
// Optional ISSUE-state timeout with error completion under GPIO_ARB_TIMEOUT_EN.
module gpio_bus_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [ADDR_W*NUM_MASTERS-1:0] m_address,
    input  logic [DATA_W*NUM_MASTERS-1:0] m_write_data,
    output logic [DATA_W-1:0]             m_read_data,
    output logic [NUM_MASTERS-1:0]        m_response,
    output logic [NUM_MASTERS-1:0]        m_error,
    output logic                          s_read,
    output logic                          s_write,
    output logic [ADDR_W-1:0]             s_address,
    output logic [DATA_W-1:0]             s_write_data,
    input  logic [DATA_W-1:0]             s_read_data,
    input  logic                          s_response
);

    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

    if (TIMEOUT < 2 || NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_params
        $error("gpio_bus_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT at least 2");
    end

    state_e                   state, state_nxt;
    logic [IDX_W-1:0]         last_grant, last_grant_nxt, arb_idx;
    logic [NUM_MASTERS-1:0]   grant_oh, grant_oh_nxt, arb_grant, req_vec;
    logic                     any_req;
    gpio_req_t                sel_req;
    logic                     s_read_nxt, s_write_nxt;
    logic [ADDR_W-1:0]        s_address_nxt;
    logic [DATA_W-1:0]        s_write_data_nxt, m_read_data_nxt;
    logic [NUM_MASTERS-1:0]   m_response_nxt, m_error_nxt;

`ifdef GPIO_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] cnt, cnt_nxt;
`endif

    assign req_vec = m_read | m_write;

    rr_arbiter #(.N(NUM_MASTERS)) u_rr_arbiter (
        .req         (req_vec),
        .last_grant  (last_grant),
        .grant_c     (arb_grant),
        .grant_idx_c (arb_idx),
        .any_req_c   (any_req)
    );

    // Winner's payload; a simultaneous read+write is treated as a write.
    always_comb begin
        sel_req.op    = m_write[arb_idx] ? OP_WRITE : OP_READ;
        sel_req.addr  = m_address[ADDR_W*32'(arb_idx) +: ADDR_W];
        sel_req.wdata = m_write_data[DATA_W*32'(arb_idx) +: DATA_W];
    end

    always_comb begin
        state_nxt        = state;
        last_grant_nxt   = last_grant;
        grant_oh_nxt     = grant_oh;
        s_read_nxt       = 1'b0;
        s_write_nxt      = 1'b0;
        s_address_nxt    = s_address;
        s_write_data_nxt = s_write_data;
        m_read_data_nxt  = m_read_data;
        m_response_nxt   = '0;
        m_error_nxt      = '0;
`ifdef GPIO_ARB_TIMEOUT_EN
        cnt_nxt          = cnt;
`endif
        case (state)
            IDLE: begin
                if (any_req) begin
                    last_grant_nxt   = arb_idx;
                    grant_oh_nxt     = arb_grant;
                    s_read_nxt       = (sel_req.op == OP_READ);
                    s_write_nxt      = (sel_req.op == OP_WRITE);
                    s_address_nxt    = sel_req.addr;
                    s_write_data_nxt = sel_req.wdata;
`ifdef GPIO_ARB_TIMEOUT_EN
                    cnt_nxt          = '0;
`endif
                    state_nxt        = ISSUE;
                end
            end
            ISSUE: begin
                if (s_response) begin
                    m_read_data_nxt = s_write ? '0 : s_read_data;
                    m_response_nxt  = grant_oh;
                    state_nxt       = RESP;
                end
`ifdef GPIO_ARB_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    m_read_data_nxt = GPIO_ARB_ERR_DATA;
                    m_response_nxt  = grant_oh;
                    m_error_nxt     = grant_oh;
                    state_nxt       = RESP;
                end else begin
                    s_read_nxt  = s_read;
                    s_write_nxt = s_write;
                    cnt_nxt     = cnt + CNT_W'(1);
                end
`else
                else begin
                    s_read_nxt  = s_read;
                    s_write_nxt = s_write;
                end
`endif
            end
            // Always back through IDLE so the answered master can drop its request.
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_grant   <= IDX_W'(NUM_MASTERS - 1);
            grant_oh     <= '0;
            s_read       <= 1'b0;
            s_write      <= 1'b0;
            s_address    <= '0;
            s_write_data <= '0;
            m_read_data  <= '0;
            m_response   <= '0;
            m_error      <= '0;
`ifdef GPIO_ARB_TIMEOUT_EN
            cnt          <= '0;
`endif
        end else begin
            state        <= state_nxt;
            last_grant   <= last_grant_nxt;
            grant_oh     <= grant_oh_nxt;
            s_read       <= s_read_nxt;
            s_write      <= s_write_nxt;
            s_address    <= s_address_nxt;
            s_write_data <= s_write_data_nxt;
            m_read_data  <= m_read_data_nxt;
            m_response   <= m_response_nxt;
            m_error      <= m_error_nxt;
`ifdef GPIO_ARB_TIMEOUT_EN
            cnt          <= cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Scoreboard bench for gpio_bus_arbiter: expected completions are queued as requests
// are driven and popped when m_response fires; peripheral returns address ^ 0xA1.
module tb_gpio_bus_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned TO = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    m_read, m_write;
    logic [32*N-1:0] m_address, m_write_data;
    logic [31:0]     m_read_data;
    logic [N-1:0]    m_response, m_error;
    logic            s_read, s_write;
    logic [31:0]     s_address, s_write_data, s_read_data;
    logic            s_response;
    logic            resp_en;
    int              cyc = 0;

    typedef struct {
        int          master;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    gpio_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_address    (m_address),
        .m_write_data (m_write_data),
        .m_read_data  (m_read_data),
        .m_response   (m_response),
        .m_error      (m_error),
        .s_read       (s_read),
        .s_write      (s_write),
        .s_address    (s_address),
        .s_write_data (s_write_data),
        .s_read_data  (s_read_data),
        .s_response   (s_response)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Zero-wait peripheral with address-derived read data.
    assign s_response  = resp_en & (s_read | s_write);
    assign s_read_data = s_address ^ 32'h0000_00A1;

    function automatic logic [31:0] periph_data(input logic [31:0] a);
        return a ^ 32'h0000_00A1;
    endfunction

    task automatic wait_resp(input int budget, output logic [N-1:0] resp, output int at,
                             output int n_rd, output int n_wr);
        resp = '0; at = -1; n_rd = 0; n_wr = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (s_read)  n_rd++;
            if (s_write) n_wr++;
            if (m_response != '0) begin
                resp = m_response;
                at   = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (s_read !== 1'b0) begin bad++; $display("FAIL reset_s_read: got %b want 0", s_read); end
        total++; if (s_write !== 1'b0) begin bad++; $display("FAIL reset_s_write: got %b want 0", s_write); end
        total++; if (s_address !== 32'h0) begin bad++; $display("FAIL reset_s_address: got %h want 0", s_address); end
        total++; if (s_write_data !== 32'h0) begin bad++; $display("FAIL reset_s_write_data: got %h want 0", s_write_data); end
        total++; if (m_read_data !== 32'h0) begin bad++; $display("FAIL reset_m_read_data: got %h want 0", m_read_data); end
        total++; if (m_response !== 2'b00) begin bad++; $display("FAIL reset_m_response: got %b want 00", m_response); end
        total++; if (m_error !== 2'b00) begin bad++; $display("FAIL reset_m_error: got %b want 00", m_error); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        exp_t e;
        m_address[31:0] = 32'h4;
        m_read = 2'b01;
        sb.push_back('{0, 32'h0000_00A5, 1'b0});
        @(negedge clk);
        total++; if (s_read !== 1'b1 || s_write !== 1'b0) begin bad++; $display("FAIL read_strobe_c1: got r=%b w=%b want r=1 w=0", s_read, s_write); end
        total++; if (s_address !== 32'h4) begin bad++; $display("FAIL read_addr: got %h want 00000004", s_address); end
        @(negedge clk);
        total++; if (s_read !== 1'b0) begin bad++; $display("FAIL read_strobe_c2: got %b want 0", s_read); end
        e = sb.pop_front();
        total++; if (m_response !== 2'b01) begin bad++; $display("FAIL read_resp: got %b want 01", m_response); end
        total++; if (m_read_data !== e.data) begin bad++; $display("FAIL read_data: got %h want %h", m_read_data, e.data); end
        total++; if (m_error !== 2'b00) begin bad++; $display("FAIL read_err: got %b want 00", m_error); end
        m_read = 2'b00;
        @(negedge clk);
        total++; if (m_response !== 2'b00 || s_read !== 1'b0) begin bad++; $display("FAIL read_no_regrant: got resp=%b s_read=%b want 00 0", m_response, s_read); end
    endtask

    task automatic test_single_write();
        exp_t        e;
        int          nw;
        logic [N-1:0] resp;
        nw = 0; resp = '0;
        m_address[63:32]    = 32'h0;
        m_write_data[63:32] = 32'h000F_FFFF;
        m_write = 2'b10;
        sb.push_back('{1, 32'h0, 1'b0});
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (s_write) begin
                nw++;
                total++; if (s_address !== 32'h0 || s_write_data !== 32'h000F_FFFF) begin bad++; $display("FAIL write_payload: got a=%h d=%h want 00000000 000fffff", s_address, s_write_data); end
            end
            if (m_response != '0) begin resp = m_response; break; end
        end
        e = sb.pop_front();
        total++; if (resp !== (N'(1) << e.master)) begin bad++; $display("FAIL write_resp: got %b want %b", resp, N'(1) << e.master); end
        total++; if (nw !== 1) begin bad++; $display("FAIL write_strobe_count: got %0d want 1", nw); end
        total++; if (m_read_data !== e.data) begin bad++; $display("FAIL write_rdata: got %h want %h", m_read_data, e.data); end
        m_write = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_contention();
        exp_t        e;
        logic [N-1:0] resp;
        int          at[4];
        int          nr, nw;
        m_address[31:0]  = 32'h10;
        m_address[63:32] = 32'h20;
        m_read = 2'b11;
        for (int j = 0; j < 4; j++)
            sb.push_back('{j % 2, periph_data((j % 2 == 0) ? 32'h10 : 32'h20), 1'b0});
        for (int j = 0; j < 4; j++) begin
            wait_resp(12, resp, at[j], nr, nw);
            e = sb.pop_front();
            total++; if (resp !== (N'(1) << e.master)) begin bad++; $display("FAIL cont_grant%0d: got %b want %b", j, resp, N'(1) << e.master); end
            total++; if (m_read_data !== e.data) begin bad++; $display("FAIL cont_data%0d: got %h want %h", j, m_read_data, e.data); end
        end
        m_read = 2'b00;
        total++; if (at[1] - at[0] !== 3) begin bad++; $display("FAIL cont_spacing: got %0d want 3", at[1] - at[0]); end
        total++; if (at[2] - at[0] !== 6) begin bad++; $display("FAIL cont_period_m0: got %0d want 6", at[2] - at[0]); end
        total++; if (at[3] - at[1] !== 6) begin bad++; $display("FAIL cont_period_m1: got %0d want 6", at[3] - at[1]); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_write_both();
        exp_t        e;
        logic [N-1:0] resp;
        int          at, nr, nw;
        m_address[31:0]    = 32'h8;
        m_write_data[31:0] = 32'h1234;
        m_read  = 2'b01;
        m_write = 2'b01;
        sb.push_back('{0, 32'h0, 1'b0});
        wait_resp(12, resp, at, nr, nw);
        e = sb.pop_front();
        total++; if (resp !== (N'(1) << e.master)) begin bad++; $display("FAIL rw_resp: got %b want %b", resp, N'(1) << e.master); end
        total++; if (nr !== 0) begin bad++; $display("FAIL rw_no_read: got %0d read cycles want 0", nr); end
        total++; if (nw !== 1) begin bad++; $display("FAIL rw_one_write: got %0d write cycles want 1", nw); end
        total++; if (m_read_data !== e.data) begin bad++; $display("FAIL rw_rdata: got %h want %h", m_read_data, e.data); end
        m_read = 2'b00; m_write = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        m_address[31:0] = 32'hC;
        resp_en = 1'b0;
        m_read  = 2'b01;
`ifdef GPIO_ARB_TIMEOUT_EN
        begin
            exp_t        e;
            logic [N-1:0] resp;
            int          at0, at, nr, nw;
            sb.push_back('{0, 32'hDEAD_BEEF, 1'b1});
            @(negedge clk);
            at0 = cyc;
            total++; if (s_read !== 1'b1) begin bad++; $display("FAIL to_issue: got %b want 1", s_read); end
            wait_resp(40, resp, at, nr, nw);
            e = sb.pop_front();
            total++; if (resp !== (N'(1) << e.master)) begin bad++; $display("FAIL to_resp: got %b want %b", resp, N'(1) << e.master); end
            total++; if (m_error !== (N'(1) << e.master)) begin bad++; $display("FAIL to_error: got %b want %b", m_error, N'(1) << e.master); end
            total++; if (m_read_data !== e.data) begin bad++; $display("FAIL to_data: got %h want %h", m_read_data, e.data); end
            total++; if (at - at0 !== int'(TO)) begin bad++; $display("FAIL to_latency: got %0d want %0d", at - at0, TO); end
            total++; if (nr !== int'(TO) - 1) begin bad++; $display("FAIL to_strobe_held: got %0d want %0d", nr, TO - 1); end
            m_read  = 2'b00;
            resp_en = 1'b1;
            repeat (2) @(negedge clk);
        end
`else
        begin
            int n_resp;
            n_resp = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (m_response != '0 || m_error != '0) n_resp++;
            end
            total++; if (n_resp !== 0) begin bad++; $display("FAIL to_no_resp: got %0d response cycles want 0", n_resp); end
            total++; if (s_read !== 1'b1) begin bad++; $display("FAIL to_strobe_held: got %b want 1", s_read); end
            m_read = 2'b00;
        end
`endif
    endtask

    task automatic test_reset_mid();
        exp_t        e;
        logic [N-1:0] resp;
        int          at, nr, nw, k;
        resp_en = 1'b0;
        m_address[63:32] = 32'h30;
        m_read = 2'b10;
        k = 0;
        while (s_read !== 1'b1 && k < 5) begin @(negedge clk); k++; end
        total++; if (s_read !== 1'b1) begin bad++; $display("FAIL rst_mid_issue: got %b want 1", s_read); end
        #2 reset = 1'b0;
        #1;
        total++; if (s_read !== 1'b0 || s_write !== 1'b0) begin bad++; $display("FAIL rst_mid_strobes: got r=%b w=%b want 0 0", s_read, s_write); end
        total++; if (m_response !== 2'b00) begin bad++; $display("FAIL rst_mid_resp: got %b want 00", m_response); end
        m_read = 2'b00;
        @(negedge clk);
        reset   = 1'b1;
        resp_en = 1'b1;
        m_address[31:0]  = 32'h40;
        m_address[63:32] = 32'h50;
        m_read = 2'b11;
        sb.push_back('{0, periph_data(32'h40), 1'b0});
        wait_resp(12, resp, at, nr, nw);
        e = sb.pop_front();
        total++; if (resp !== (N'(1) << e.master)) begin bad++; $display("FAIL rst_first_grant: got %b want %b", resp, N'(1) << e.master); end
        total++; if (m_read_data !== e.data) begin bad++; $display("FAIL rst_first_data: got %h want %h", m_read_data, e.data); end
        m_read = 2'b00;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        m_read = '0; m_write = '0; m_address = '0; m_write_data = '0; resp_en = 1'b1;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_read_write_both();
        test_timeout();
        test_reset_mid();
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
